regfile_2r1w: RTL

REGFILE_2R1W -- requirements
Module: regfile_2r1w

---
 rtl/regfile_2r1w_pkg.sv | 6 +
 rtl/regfile_2r1w_reg_word.sv | 16 +
 rtl/regfile_2r1w.sv | 59 +++++
 3 files changed

// File: rtl/regfile_2r1w_pkg.sv
// regfile_2r1w_pkg: shared defaults for the two-read one-write register file.
package regfile_2r1w_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;
endpackage

// File: rtl/regfile_2r1w_reg_word.sv
// reg_word: one enabled storage word with asynchronous active-low clear.
module reg_word #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] word_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) word_q <= '0;
    else if (en) word_q <= d;
  assign q = word_q;
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with two registered read ports, one write port,
// a hardwired-zero register 0 and write-first bypass on read/write collision.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_b
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_ADDR);
  logic [DEPTH-1:0][DATA_W-1:0] words;
  logic [DATA_W-1:0] rdata_a_d, rdata_b_d, rdata_a_q, rdata_b_q;
  logic rvalid_a_q, rvalid_b_q;
  assign words[0] = '0;
  for (genvar g = 1; g < DEPTH; g++) begin : g_word
    reg_word #(.DATA_W(DATA_W)) u_word (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (we && waddr == ADDR_W'(g)),
      .d    (wdata),
      .q    (words[g])
    );
  end
  // Bypass returns the word being written this edge; address 0 always reads the stored zero.
  always_comb begin
    rdata_a_d = (we && waddr == raddr_a && raddr_a != ZERO) ? wdata : words[raddr_a];
    rdata_b_d = (we && waddr == raddr_b && raddr_b != ZERO) ? wdata : words[raddr_b];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      rvalid_a_q <= re_a;
      rvalid_b_q <= re_b;
      if (re_a) rdata_a_q <= rdata_a_d;
      if (re_b) rdata_b_q <= rdata_b_d;
    end
  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
endmodule
